key_cmd_sched: RTL and testbench

- Command scheduler between the per-button debouncers and the audio datapath configuration port.
- Takes NKEYS debounced active-low key levels, detects presses and generates auto-repeat while a volume key is held.
- Arbitrates pending key events round-robin and applies each event to volume/mode/mute state.
- Pushes each update to the datapath over a req/ack handshake, with an ack timeout.

---
 rtl/key_cmd_pkg.sv | 30 +++
 rtl/key_event_gen.sv | 62 ++++++
 rtl/key_cmd_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_key_cmd_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg
//   Shared constants for the key command scheduler: fixed key functions,
//   configuration register addresses and the scheduler FSM encoding.
//   Imported by key_event_gen and key_cmd_sched.
package key_cmd_pkg;

  // Fixed function of each key input bit.
  localparam int KEY_VUP  = 0;
  localparam int KEY_VDN  = 1;
  localparam int KEY_MODE = 2;
  localparam int KEY_MUTE = 3;

  // Datapath configuration register addresses.
  localparam logic [1:0] ADDR_VOL  = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_MUTE = 2'd2;

  // Scheduler FSM: grant in IDLE, apply in UPDATE, handshake in WAIT.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_WAIT   = 2'd2
  } sched_state_e;

  // True for keys that auto-repeat while held (volume keys only).
  function automatic bit key_repeats(input int key);
    return (key == KEY_VUP) || (key == KEY_VDN);
  endfunction

endpackage

// File: rtl/key_event_gen.sv
// key_event_gen
//   Per-key event source: 2-flop synchronizer for the asynchronous
//   active-low key level, one extra register for falling-edge detection,
//   and an optional hold/auto-repeat counter.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   key_n  in   debounced key level, 0 = pressed
//   pulse  out  1-cycle event: press edge or auto-repeat tick
module key_event_gen
  import key_cmd_pkg::*;
#(
  parameter int HOLD_CYCLES   = 24000,
  parameter int REPEAT_CYCLES = 4800,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] hold_cnt;
  logic             pressed;
  logic             press;
  logic             rep_hit;

  assign pressed = ~sync2;
  assign press   = prev & ~sync2;
  // Reloading to HOLD-REPEAT makes every later tick exactly REPEAT_CYCLES
  // apart while sharing the single comparator against HOLD_CYCLES-1.
  assign rep_hit = REPEAT_EN && pressed && (hold_cnt == HOLD_LAST);
  assign pulse   = press | rep_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
      if (!REPEAT_EN || !pressed) begin
        hold_cnt <= '0;
      end else if (rep_hit) begin
        hold_cnt <= HOLD_RELOAD;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_cmd_sched.sv
// key_cmd_sched
//   Turns debounced key presses (plus auto-repeat on the volume keys) into
//   volume/mode/mute updates and pushes each update to the audio datapath.
// Ports:
//   clock      in   system clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   key_n      in   NKEYS debounced key levels, 0 = pressed (async)
//   cfg_req    out  configuration request
//   cfg_ack    in   datapath accept
//   cfg_addr   out  0 = volume, 1 = mode, 2 = mute
//   cfg_data   out  new value, zero-extended
//   volume     out  current volume
//   mode       out  current effect mode
//   mute       out  current mute
//   busy       out  FSM not in IDLE
//   err        out  sticky ack-timeout flag
//   fsm_state  out  current scheduler state (observability)
//
// Handshake: cfg_req rises with cfg_addr/cfg_data already valid and all
// three stay stable until cfg_ack is sampled high on a clock edge (or the
// ack timeout expires); cfg_req drops on that same edge. cfg_ack is only
// looked at while a request is outstanding.
module key_cmd_sched
  import key_cmd_pkg::*;
#(
  parameter int NKEYS         = 4,
  parameter int VOL_W         = 5,
  parameter int VOL_MAX       = 31,
  parameter int VOL_RST       = 16,
  parameter int NMODES        = 4,
  parameter int HOLD_CYCLES   = 24000,
  parameter int REPEAT_CYCLES = 4800,
  parameter int ACK_TIMEOUT   = 1023,
  // Derived from NMODES; not meant to be overridden.
  parameter int MODE_W        = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NKEYS-1:0]   key_n,
  output logic               cfg_req,
  input  logic               cfg_ack,
  output logic [1:0]         cfg_addr,
  output logic [7:0]         cfg_data,
  output logic [VOL_W-1:0]   volume,
  output logic [MODE_W-1:0]  mode,
  output logic               mute,
  output logic               busy,
  output logic               err,
  output sched_state_e       fsm_state
);

  localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NKEYS - 1);
  localparam logic [VOL_W-1:0]  VOL_TOP   = VOL_W'(VOL_MAX);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NMODES - 1);

  sched_state_e      state;
  sched_state_e      state_n;
  logic [NKEYS-1:0]  key_evt;
  logic [NKEYS-1:0]  pending;
  logic [NKEYS-1:0]  take_mask;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  grant_c;
  logic [IDX_W-1:0]  grant_inc;
  logic              any_pending;
  logic              take;
  logic              finish;
  logic              timeout;
  logic [TO_W-1:0]   wait_cnt;
  logic [VOL_W-1:0]  vol_up;
  logic [VOL_W-1:0]  vol_dn;
  logic [MODE_W-1:0] mode_nx;

  // ---------------------------------------------------------------------
  // Per-key event generation
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_event_gen #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (key_repeats(i))
    ) u_evt (
      .clock(clock),
      .reset(reset),
      .key_n(key_n[i]),
      .pulse(key_evt[i])
    );
  end

  // ---------------------------------------------------------------------
  // Round-robin pick: first pending key at or after ptr, wrapping.
  // ---------------------------------------------------------------------
  always_comb begin
    int               j;
    logic [IDX_W-1:0] idx;
    j           = 0;
    idx         = '0;
    grant_c     = ptr;
    any_pending = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      j = int'(ptr) + i;
      if (j >= NKEYS) j = j - NKEYS;
      idx = IDX_W'(j);
      if (!any_pending && pending[idx]) begin
        any_pending = 1'b1;
        grant_c     = idx;
      end
    end
  end

  always_comb begin
    take_mask = '0;
    if (take) take_mask[grant_c] = 1'b1;
  end

  assign grant_inc = (grant == IDX_LAST) ? '0 : grant + 1'b1;

  // Saturating / wrapping next values of the controlled state.
  assign vol_up  = (volume >= VOL_TOP) ? VOL_TOP : volume + 1'b1;
  assign vol_dn  = (volume == '0) ? '0 : volume - 1'b1;
  assign mode_nx = (mode == MODE_LAST) ? '0 : mode + 1'b1;

  // ---------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_pending) begin
          take    = 1'b1;
          state_n = S_UPDATE;
        end
      end
      S_UPDATE: state_n = S_WAIT;
      S_WAIT: begin
        if (cfg_ack) begin
          finish  = 1'b1;
          state_n = S_IDLE;
        end else if (wait_cnt == TO_LAST) begin
          finish  = 1'b1;
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // ---------------------------------------------------------------------
  // Pending bits, command application and request outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      ptr      <= '0;
      grant    <= '0;
      wait_cnt <= '0;
      volume   <= VOL_W'(VOL_RST);
      mode     <= '0;
      mute     <= 1'b0;
      cfg_req  <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
      err      <= 1'b0;
    end else begin
      // New events OR in after the grant clear, so a same-cycle event on
      // the granted key stays pending instead of being lost.
      pending <= (pending & ~take_mask) | key_evt;

      if (take) grant <= grant_c;

      if (state == S_UPDATE) begin
        cfg_req  <= 1'b1;
        wait_cnt <= '0;
        case (int'(grant))
          KEY_VUP: begin
            volume   <= vol_up;
            cfg_addr <= ADDR_VOL;
            cfg_data <= 8'(vol_up);
          end
          KEY_VDN: begin
            volume   <= vol_dn;
            cfg_addr <= ADDR_VOL;
            cfg_data <= 8'(vol_dn);
          end
          KEY_MODE: begin
            mode     <= mode_nx;
            cfg_addr <= ADDR_MODE;
            cfg_data <= 8'(mode_nx);
          end
          KEY_MUTE: begin
            mute     <= ~mute;
            cfg_addr <= ADDR_MUTE;
            cfg_data <= {7'd0, ~mute};
          end
          default: begin
            // Keys without a function re-send the current volume.
            cfg_addr <= ADDR_VOL;
            cfg_data <= 8'(volume);
          end
        endcase
      end

      if (state == S_WAIT) begin
        if (finish) begin
          cfg_req <= 1'b0;
          ptr     <= grant_inc;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        // The state change already applied is kept on timeout.
        if (timeout) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_sched.sv
module tb_key_cmd_sched;
  import key_cmd_pkg::*;

  localparam int NKEYS         = 4;
  localparam int VOL_MAX       = 31;
  localparam int VOL_RST       = 16;
  localparam int NMODES        = 4;
  localparam int HOLD_CYCLES   = 24000;
  localparam int REPEAT_CYCLES = 4800;
  localparam int ACK_TIMEOUT   = 1023;

  // ---------------- clock / reset ----------------
  logic         clock;
  logic         reset;
  logic [3:0]   key_n;
  logic         cfg_req;
  logic         cfg_ack;
  logic [1:0]   cfg_addr;
  logic [7:0]   cfg_data;
  logic [4:0]   volume;
  logic [1:0]   mode;
  logic         mute;
  logic         busy;
  logic         err;
  sched_state_e fsm_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  key_cmd_sched dut (
    .clock    (clock),
    .reset    (reset),
    .key_n    (key_n),
    .cfg_req  (cfg_req),
    .cfg_ack  (cfg_ack),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .volume   (volume),
    .mode     (mode),
    .mute     (mute),
    .busy     (busy),
    .err      (err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_vol, m_mode, m_mute, m_ptr, m_err;

  task automatic m_reset();
    m_vol = VOL_RST; m_mode = 0; m_mute = 0; m_ptr = 0; m_err = 0;
  endtask

  task automatic m_apply(input int k);
    int addr, data;
    addr = 0; data = 0;
    case (k)
      0: begin m_vol = (m_vol < VOL_MAX) ? m_vol + 1 : VOL_MAX; addr = 0; data = m_vol; end
      1: begin m_vol = (m_vol > 0) ? m_vol - 1 : 0; addr = 0; data = m_vol; end
      2: begin m_mode = (m_mode + 1) % NMODES; addr = 1; data = m_mode; end
      default: begin m_mute = 1 - m_mute; addr = 2; data = m_mute; end
    endcase
    exp_q.push_back({2'(addr), 8'(data)});
    m_ptr = (k + 1) % NKEYS;
  endtask

  // Keys pressed together are serviced starting at the pointer.
  task automatic m_keys(input logic [3:0] mask);
    int start, k;
    start = m_ptr;
    for (int i = 0; i < NKEYS; i++) begin
      k = (start + i) % NKEYS;
      if (mask[k]) m_apply(k);
    end
  endtask

  // ---------------- ack responder ----------------
  int ack_delay = 0;
  bit ack_en    = 1'b1;

  initial begin
    int wcnt;
    wcnt    = 0;
    cfg_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (cfg_ack) begin
        cfg_ack = 1'b0;
        wcnt    = 0;
      end else if (cfg_req && ack_en && !reset) begin
        if (wcnt >= ack_delay) begin
          cfg_ack = 1'b1;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- request monitor ----------------
  initial begin
    logic       req_prev;
    logic [1:0] addr_prev;
    logic [7:0] data_prev;
    req_prev = 1'b0; addr_prev = '0; data_prev = '0;
    forever begin
      @(negedge clock);
      if (cfg_req && req_prev) begin
        check("hold_addr", 32'(cfg_addr), 32'(addr_prev));
        check("hold_data", 32'(cfg_data), 32'(data_prev));
      end
      if (cfg_req && !req_prev) obs_q.push_back({cfg_addr, cfg_data});
      req_prev  = cfg_req;
      addr_prev = cfg_addr;
      data_prev = cfg_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge clock);
    key_n = ~mask;
    repeat (hold) @(negedge clock);
    key_n = 4'hF;
  endtask

  task automatic settle();
    int idle, n;
    idle = 0; n = 0;
    while (idle < 8 && n < 4000) begin
      @(negedge clock);
      n++;
      if (!busy && !cfg_req) idle++;
      else idle = 0;
    end
    check("settle", idle, 8);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_req"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    check({tag, "_volume"}, 32'(volume), m_vol);
    check({tag, "_mode"}, 32'(mode), m_mode);
    check({tag, "_mute"}, 32'(mute), m_mute);
    check({tag, "_err"}, 32'(err), m_err);
    check({tag, "_req_idle"}, 32'(cfg_req), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int reps, n, hi;
    logic [3:0] mask;
    reset = 1'b1;
    key_n = 4'hF;
    m_reset();
    repeat (3) @(negedge clock);
    check("rst_req", 32'(cfg_req), 0);
    check("rst_addr", 32'(cfg_addr), 0);
    check("rst_data", 32'(cfg_data), 0);
    check("rst_volume", 32'(volume), VOL_RST);
    check("rst_mode", 32'(mode), 0);
    check("rst_mute", 32'(mute), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    reset = 1'b0;

    // single vol-up press, ack one cycle late
    ack_delay = 1;
    m_keys(4'b0001); press(4'b0001, 10); settle(); compare("vup");

    // simultaneous vol-up + mode from pointer 0, then mute + vol-up from pointer 3
    do_reset();
    ack_delay = 0;
    m_keys(4'b0101); press(4'b0101, 6); settle(); compare("rr_a");
    m_keys(4'b1001); press(4'b1001, 6); settle(); compare("rr_b");

    // saturation at the top, then at zero
    for (int i = 0; i < 16; i++) begin m_keys(4'b0001); press(4'b0001, 4); settle(); end
    compare("sat_top");
    for (int i = 0; i < 33; i++) begin m_keys(4'b0010); press(4'b0010, 4); settle(); end
    compare("sat_zero");

    // auto-repeat on a long vol-down hold
    do_reset();
    n    = HOLD_CYCLES + 2 * REPEAT_CYCLES + 10;
    reps = (n >= HOLD_CYCLES) ? 1 + (n - HOLD_CYCLES) / REPEAT_CYCLES : 0;
    for (int i = 0; i <= reps; i++) m_keys(4'b0010);
    press(4'b0010, n); settle(); compare("repeat");

    // mode wrap and mute toggle
    for (int i = 0; i < 4; i++) begin m_keys(4'b0100); press(4'b0100, 5); settle(); end
    compare("mode_wrap");
    for (int i = 0; i < 2; i++) begin m_keys(4'b1000); press(4'b1000, 5); settle(); end
    compare("mute_tog");

    // random key combinations and ack latencies
    for (int i = 0; i < 40; i++) begin
      mask      = 4'($urandom_range(1, 15));
      ack_delay = $urandom_range(0, 5);
      m_keys(mask);
      press(mask, $urandom_range(4, 12));
      settle();
    end
    compare("random");

    // ack timeout
    ack_en = 1'b0;
    m_keys(4'b0100);
    @(negedge clock); key_n = 4'b1011;
    n = 0;
    while (!cfg_req && n < 100) begin @(negedge clock); n++; end
    check("to_req_seen", 32'(cfg_req), 1);
    key_n = 4'hF;
    hi = 0;
    while (cfg_req && hi < 3000) begin hi++; @(negedge clock); end
    check("to_req_cycles", hi, ACK_TIMEOUT);
    m_err = 1;
    settle(); compare("timeout");

    // reset during a later WAIT
    m_keys(4'b0001);
    @(negedge clock); key_n = 4'b1110;
    n = 0;
    while (!cfg_req && n < 100) begin @(negedge clock); n++; end
    check("mw_req_seen", 32'(cfg_req), 1);
    key_n = 4'hF;
    repeat (5) @(negedge clock);
    check("mw_err_before", 32'(err), 1);
    check("mw_count", obs_q.size(), exp_q.size());
    if (obs_q.size() > 0 && exp_q.size() > 0) check("mw_req", 32'(obs_q[0]), 32'(exp_q[0]));
    obs_q.delete(); exp_q.delete();
    reset = 1'b1;
    #1;
    check("mw_req_drop", 32'(cfg_req), 0);
    check("mw_volume", 32'(volume), VOL_RST);
    check("mw_err", 32'(err), 0);
    check("mw_busy", 32'(busy), 0);
    check("mw_addr", 32'(cfg_addr), 0);
    check("mw_data", 32'(cfg_data), 0);
    m_reset();
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    ack_en = 1'b1;
    settle(); compare("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
